// File: rtl/ssi_pkg.sv
// Shared definitions for the SSI gate-array self-test controller.
package ssi_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CHECK   = 2'd2,
    DONE_ST = 2'd3
  } state_e;

  // Bit positions of each gate on the GATE_OUT bus
  localparam int GATE_AND   = 0;
  localparam int GATE_OR    = 1;
  localparam int GATE_NOT   = 2;
  localparam int GATE_NAND  = 3;
  localparam int GATE_NOR   = 4;
  localparam int GATE_EXOR  = 5;
  localparam int GATE_EXNOR = 6;
  localparam int GATE_TRI   = 7;

  // Last stimulus vector of a run
  localparam logic [1:0] VEC_LAST = 2'b11;

  // Width of the settle counter (holds SETTLE_CYC-1, up to 14)
  localparam int CNT_W = 4;

endpackage

// File: rtl/ssi_expect.sv
// Expected gate outputs and compare mask for one 2-bit stimulus vector.
// The tri-state buffer is only checked while its enable (b) is high.
module ssi_expect
  import ssi_pkg::*;
(
  input  logic [1:0] vec_i,
  output logic [7:0] exp_o,
  output logic [7:0] mask_o
);

  logic a;
  logic b;

  assign a = vec_i[0];
  assign b = vec_i[1];

  // Truth table of every gate for the current vector
  always_comb begin
    exp_o             = '0;
    mask_o            = 8'hFF;
    exp_o[GATE_AND]   = a & b;
    exp_o[GATE_OR]    = a | b;
    exp_o[GATE_NOT]   = ~b;
    exp_o[GATE_NAND]  = ~(a & b);
    exp_o[GATE_NOR]   = ~(a | b);
    exp_o[GATE_EXOR]  = a ^ b;
    exp_o[GATE_EXNOR] = ~(a ^ b);
    exp_o[GATE_TRI]   = a;
    mask_o[GATE_TRI]  = b;
  end

endmodule

// File: rtl/ssi_bist.sv
// Self-test controller for the SSI gate array: steps GATE_IN through
// 00..11, waits SETTLE_CYC cycles per vector, then compares GATE_OUT
// against the expected truth table and accumulates a sticky fail mask.
module ssi_bist
  import ssi_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  output logic [1:0] GATE_IN,
  input  logic [7:0] GATE_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [7:0] FAIL_MASK
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       vec_q, vec_d;
  logic [7:0]       fail_q, fail_d;
  logic             pass_q, pass_d;

  logic [7:0]       exp_val;
  logic [7:0]       cmp_mask;
  logic [7:0]       mismatch;

  ssi_expect u_expect (
    .vec_i  (vec_q),
    .exp_o  (exp_val),
    .mask_o (cmp_mask)
  );

  // Per-bit mismatch; X/Z on a checked bit counts as a failure
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < 8; i++) begin
      mismatch[i] = cmp_mask[i] & (GATE_OUT[i] !== exp_val[i]);
    end
  end

  // Next-state logic for the run sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = SETTLE;
          vec_d   = 2'b00;
          cnt_d   = CNT_LOAD;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CHECK: begin
        fail_d = fail_q | mismatch;
        if (vec_q == VEC_LAST) begin
          // Verdict is registered here so it is already valid while DONE is high
          state_d = DONE_ST;
          pass_d  = ((fail_q | mismatch) == 8'h00);
        end else begin
          state_d = SETTLE;
          vec_d   = vec_q + 2'd1;
          cnt_d   = CNT_LOAD;
        end
      end
      DONE_ST: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= 2'b00;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign GATE_IN   = vec_q;
  assign BUSY      = (state_q == SETTLE) || (state_q == CHECK);
  assign DONE      = (state_q == DONE_ST);
  assign PASS      = pass_q;
  assign FAIL_MASK = fail_q;

endmodule

// File: tb/tb_ssi_bist.sv
// Bench for ssi_bist: three instances (SETTLE_CYC = 2, 1, 15) share START and
// reset; each sees a gate-array model driven from its own GATE_IN with an
// optional stuck-at fault. A timeline model predicts every output each cycle.
module tb_ssi_bist;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic [1:0] gin  [3];
  logic [7:0] gout [3];
  logic       busy [3];
  logic       done [3];
  logic       pass [3];
  logic [7:0] fm   [3];

  // Fault injection: when f_en, gate f_g is forced to f_val on vectors in f_vm
  logic       f_en;
  logic [2:0] f_g;
  logic       f_val;
  logic [3:0] f_vm;
  logic       junk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Model state per instance
  int       cyc = 0;
  int       t0  [3];
  logic     run [3];
  logic [7:0] acc [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      t0[i] = 0; run[i] = 1'b0; acc[i] = 8'h00;
    end
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int sval(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  // Healthy gate array; bit 7 only meaningful while enable b is high
  function automatic logic [7:0] good_out(logic [1:0] v);
    logic a, b;
    logic [7:0] r;
    a = v[0]; b = v[1];
    r = {a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~b, a | b, a & b};
    return r;
  endfunction

  function automatic logic [7:0] drive(logic [1:0] v, logic en, logic [2:0] g,
                                        logic val, logic [3:0] vm, logic j);
    logic [7:0] r;
    r = good_out(v);
    if (!v[1]) r[7] = j;
    if (en && vm[v]) r[g] = val;
    return r;
  endfunction

  // Gates that must be reported as failing when vector v is checked
  function automatic logic [7:0] mm(logic [1:0] v, logic en, logic [2:0] g,
                                     logic val, logic [3:0] vm);
    logic [7:0] gd, r;
    gd = good_out(v);
    r  = 8'h00;
    if (en && vm[v] && !(g == 3'd7 && !v[1]) && (val != gd[g])) r[g] = 1'b1;
    return r;
  endfunction

  assign gout[0] = drive(gin[0], f_en, f_g, f_val, f_vm, junk);
  assign gout[1] = drive(gin[1], f_en, f_g, f_val, f_vm, junk);
  assign gout[2] = drive(gin[2], f_en, f_g, f_val, f_vm, junk);

  ssi_bist #(.SETTLE_CYC(2)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .START(START), .GATE_IN(gin[0]), .GATE_OUT(gout[0]),
    .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .FAIL_MASK(fm[0]));
  ssi_bist #(.SETTLE_CYC(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(START), .GATE_IN(gin[1]), .GATE_OUT(gout[1]),
    .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .FAIL_MASK(fm[1]));
  ssi_bist #(.SETTLE_CYC(15)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .START(START), .GATE_IN(gin[2]), .GATE_OUT(gout[2]),
    .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .FAIL_MASK(fm[2]));

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at cycle %0d", name, idx, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) junk <= 1'($urandom_range(0, 1));

  // Timeline model: a run starting after edge t0 is busy for 4*(S+1) cycles,
  // vector v occupies cycles v*(S+1)..(v+1)*(S+1)-1, its check is the last of those.
  always @(posedge CLK) begin
    int s, L, kp, nt0;
    logic [7:0] nacc;
    logic nrun;
    for (int i = 0; i < 3; i++) begin
      s = sval(i); L = 4 * (s + 1); kp = cyc - t0[i];
      nacc = acc[i]; nrun = run[i]; nt0 = t0[i];
      if (!RST_N) begin
        nrun = 1'b0; nacc = 8'h00;
      end else begin
        if (nrun && kp >= 0 && kp < L && ((kp + 1) % (s + 1)) == 0)
          nacc = nacc | mm(2'((kp + 1) / (s + 1) - 1), f_en, f_g, f_val, f_vm);
        if (START && (!nrun || kp > L)) begin
          nrun = 1'b1; nt0 = cyc + 1; nacc = 8'h00;
        end
      end
      acc[i] <= nacc; run[i] <= nrun; t0[i] <= nt0;
    end
    cyc <= cyc + 1;
  end

  // Compare every instance against the model on every cycle
  always @(negedge CLK) begin
    int s, L, k;
    logic eb, ed, ep;
    logic [1:0] eg;
    logic [7:0] ef;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        s = sval(i); L = 4 * (s + 1); k = cyc - t0[i];
        eb = 1'b0; ed = 1'b0; ep = 1'b0; eg = 2'b00; ef = 8'h00;
        if (run[i]) begin
          ef = acc[i];
          if (k < L) begin
            eb = 1'b1; eg = 2'(k / (s + 1));
          end else begin
            eg = 2'b11; ed = (k == L); ep = (acc[i] == 8'h00);
          end
        end
        chk("busy", i, 32'(busy[i]), 32'(eb));
        chk("done", i, 32'(done[i]), 32'(ed));
        chk("pass", i, 32'(pass[i]), 32'(ep));
        chk("gate_in", i, 32'(gin[i]), 32'(eg));
        chk("fail_mask", i, 32'(fm[i]), 32'(ef));
      end
    end
  end

  task automatic set_fault(logic en, logic [2:0] g, logic val, logic [3:0] vm);
    f_en = en; f_g = g; f_val = val; f_vm = vm;
  endtask

  // Start a run and wait (bounded) for DONE on instance 0
  task automatic run0(output logic [7:0] fm_start, output logic [7:0] fm_end,
                      output logic p_end, output int dc);
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
    fm_start = fm[0];
    dc = -1;
    for (int c = 0; c < 100; c++) begin
      if (done[0]) begin dc = c; break; end
      @(negedge CLK);
    end
    fm_end = fm[0];
    p_end  = pass[0];
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (!busy[0] && !busy[1] && !busy[2] && !done[0] && !done[1] && !done[2]) begin
        ok = 1'b1; break;
      end
    end
    chk("idle_timeout", 0, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [7:0] fs, fe;
    logic p;
    int dc;
    int first [3];
    int bcnt  [3];

    RST_N = 1'b0; START = 1'b0;
    set_fault(1'b0, 3'd0, 1'b0, 4'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    chk_en = 1'b1;

    // Reset values
    chk("rst_gate_in", 0, 32'(gin[0]), 32'd0);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_done", 0, 32'(done[0]), 32'd0);
    chk("rst_pass", 0, 32'(pass[0]), 32'd0);
    chk("rst_fail_mask", 0, 32'(fm[0]), 32'd0);

    // Healthy gates; run lengths of all three settle settings; START while busy
    for (int i = 0; i < 3; i++) begin first[i] = -1; bcnt[i] = 0; end
    @(negedge CLK) START = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
        if (first[i] < 0 && busy[i]) bcnt[i]++;
        if (first[i] < 0 && done[i]) first[i] = c;
      end
      if (c == 0 || c == 3 || c == 6 || c == 9) chk("gin_step", 0, 32'(gin[0]), 32'(c / 3));
      if (c == 11) chk("done_early", 0, 32'(done[0]), 32'd0);
      if (c == 12) begin
        chk("done_t13", 0, 32'(done[0]), 32'd1);
        chk("pass_good", 0, 32'(pass[0]), 32'd1);
        chk("mask_good", 0, 32'(fm[0]), 32'h00);
      end
      if (c == 13) chk("no_restart_in_done", 0, 32'(busy[0]), 32'd0);
      START = (c == 5 || c == 12);
    end
    START = 1'b0;
    chk("done_cyc_s2", 0, 32'(first[0]), 32'd12);
    chk("done_cyc_s1", 1, 32'(first[1]), 32'd8);
    chk("done_cyc_s15", 2, 32'(first[2]), 32'd64);
    chk("busy_len_s2", 0, 32'(bcnt[0]), 32'd12);
    chk("busy_len_s1", 1, 32'(bcnt[1]), 32'd8);
    chk("busy_len_s15", 2, 32'(bcnt[2]), 32'd64);
    wait_idle();

    // NAND stuck at 1: only vector 11 mismatches
    set_fault(1'b1, 3'd3, 1'b1, 4'hF);
    run0(fs, fe, p, dc);
    chk("nand_done_cyc", 0, 32'(dc), 32'd12);
    chk("nand_mask", 0, 32'(fe), 32'h08);
    chk("nand_pass", 0, 32'(p), 32'd0);

    // Gates fixed: mask clears at START, run passes
    set_fault(1'b0, 3'd0, 1'b0, 4'h0);
    run0(fs, fe, p, dc);
    chk("rerun_mask_start", 0, 32'(fs), 32'h00);
    chk("rerun_mask", 0, 32'(fe), 32'h00);
    chk("rerun_pass", 0, 32'(p), 32'd1);

    // TRI forced 0 at vector 11 (floating output with E=0 already exercised)
    set_fault(1'b1, 3'd7, 1'b0, 4'h8);
    run0(fs, fe, p, dc);
    chk("tri_mask", 0, 32'(fe), 32'h80);
    chk("tri_pass", 0, 32'(p), 32'd0);
    wait_idle();

    // Reset pulse during vector-10 settle after AND already failed at 00
    set_fault(1'b1, 3'd0, 1'b1, 4'hF);
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
    repeat (6) @(negedge CLK);
    chk("pre_rst_gin", 0, 32'(gin[0]), 32'd2);
    chk("pre_rst_mask", 0, 32'(fm[0]), 32'h01);
    RST_N = 1'b0;
    @(negedge CLK) RST_N = 1'b1;
    chk("post_rst_gin", 0, 32'(gin[0]), 32'd0);
    chk("post_rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("post_rst_mask", 0, 32'(fm[0]), 32'h00);
    dc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (done[0]) dc++;
    end
    chk("post_rst_no_done", 0, 32'(dc), 32'd0);

    // Randomized traffic: START pulses, faults, occasional reset
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      START = ($urandom_range(0, 7) == 0);
      RST_N = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 29) == 0)
        set_fault(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    START = 1'b0; RST_N = 1'b1;
    wait_idle();
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
